// File: rtl/axi_ram_slave_pkg.sv
// Shared AXI definitions for the RAM slave: FSM state encoding and response codes.
// Pure constants. They carry no latency and no flow control.
package axi_ram_slave_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD    = 2'd1;
  localparam logic [1:0] ST_WR    = 2'd2;
  localparam logic [1:0] ST_BRESP = 2'd3;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_ram_slave_if.sv
// AXI4 read/write channel bundle (INCR, 32-bit beats) between a master and the RAM slave.
// Wiring only. Each channel uses valid/ready backpressure.
interface axi_ram_slave_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );

endinterface

// File: rtl/axi_ram_bank.sv
// Byte-enabled single-port RAM of 2^ADDR_W 32-bit words with a registered read output.
// Read data appears 1 cycle after en. dout holds while en is low. No flow control.
module axi_ram_bank #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 INCR RAM slave with one transaction in flight and alternating AR/AW grants.
// First rvalid comes 2 cycles after AR. rready/bready stalls hold outputs; wready stays high in WR.
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input logic            aclk,
  input logic            aresetn,
  axi_ram_slave_if.slave bus
);

  logic [1:0]        state;
  logic              prefer_rd;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        len;
  logic [7:0]        beat;
  logic              first_rd;
  logic              early_last;
  logic [3:0]        rid_q;
  logic [3:0]        bid_q;
  logic              rvalid_q;
  logic              bvalid_q;
  axi_resp_t         bresp_q;

  logic              grant_rd;
  logic              grant_wr;
  logic              r_hs;
  logic              w_hs;
  logic              last_beat;
  logic              rd_en;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [31:0]       ram_dout;
  logic              unused_addr_bits;

  // Address bits outside the word index are ignored, so the RAM aliases across the space.
  assign unused_addr_bits = ^{bus.araddr[31:ADDR_W+2], bus.araddr[1:0],
                              bus.awaddr[31:ADDR_W+2], bus.awaddr[1:0]};

  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (aresetn && state == ST_IDLE) begin
      if (bus.arvalid && bus.awvalid) begin
        grant_rd = prefer_rd;
        grant_wr = !prefer_rd;
      end else begin
        grant_rd = bus.arvalid;
        grant_wr = bus.awvalid;
      end
    end
  end

  assign last_beat = (beat == len);
  assign r_hs      = rvalid_q && bus.rready;
  assign w_hs      = (state == ST_WR) && bus.wvalid;
  // Fetch the next word while the current beat is being accepted, so beats stream back-to-back.
  assign rd_en     = (state == ST_RD) && (first_rd || (r_hs && !last_beat));
  assign ram_en    = rd_en || w_hs;
  assign ram_we    = w_hs ? bus.wstrb : 4'b0000;

  assign bus.arready = grant_rd;
  assign bus.awready = grant_wr;
  assign bus.wready  = (state == ST_WR);
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rvalid_q ? ram_dout : 32'h0;
  assign bus.rlast   = rvalid_q && last_beat;
  assign bus.rid     = rid_q;
  assign bus.rresp   = RESP_OKAY;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      prefer_rd  <= 1'b1;
      idx        <= '0;
      len        <= 8'd0;
      beat       <= 8'd0;
      first_rd   <= 1'b0;
      early_last <= 1'b0;
      rid_q      <= 4'd0;
      bid_q      <= 4'd0;
      rvalid_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_rd) begin
            state     <= ST_RD;
            prefer_rd <= 1'b0;
            idx       <= bus.araddr[ADDR_W+1:2];
            len       <= bus.arlen;
            beat      <= 8'd0;
            first_rd  <= 1'b1;
            rid_q     <= bus.arid;
          end else if (grant_wr) begin
            state      <= ST_WR;
            prefer_rd  <= 1'b1;
            idx        <= bus.awaddr[ADDR_W+1:2];
            len        <= bus.awlen;
            beat       <= 8'd0;
            early_last <= 1'b0;
            bid_q      <= bus.awid;
          end
        end
        ST_RD: begin
          if (rd_en) begin
            idx      <= idx + 1'b1;
            first_rd <= 1'b0;
            rvalid_q <= 1'b1;
          end else if (r_hs) begin
            rvalid_q <= 1'b0;
          end
          if (r_hs) begin
            beat <= beat + 8'd1;
            if (last_beat) state <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (w_hs) begin
            idx  <= idx + 1'b1;
            beat <= beat + 8'd1;
            // The burst length decides the end; wlast only grades the response.
            if (last_beat) begin
              state    <= ST_BRESP;
              bvalid_q <= 1'b1;
              bresp_q  <= (bus.wlast && !early_last) ? RESP_OKAY : RESP_SLVERR;
            end else if (bus.wlast) begin
              early_last <= 1'b1;
            end
          end
        end
        ST_BRESP: begin
          if (bvalid_q && bus.bready) begin
            bvalid_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axi_ram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk  (aclk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (idx),
    .din  (bus.wdata),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: arbitration, bursts, strobes, wrap, stalls, bad wlast, reset.
module tb_axi_ram_slave;

  logic aclk;
  logic aresetn;
  axi_ram_slave_if bus();

  axi_ram_slave #(.ADDR_W(12)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic [15:0] lastmask;
  logic [3:0]  rid_seen;
  int          rd_first;
  int          stable_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb,
                           input int wlast_at, input logic [3:0] id_in,
                           output logic [1:0] resp, output logic [3:0] id_out);
    int t;
    bus.awaddr = addr; bus.awlen = len; bus.awid = id_in; bus.awvalid = 1'b1;
    t = 0; #1;
    while (!bus.awready && t < 50) begin @(negedge aclk); #1; t++; end
    if (t >= 50) timeout_fail("aw_handshake");
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wd[i]; bus.wstrb = strb; bus.wlast = (i == wlast_at); bus.wvalid = 1'b1;
      t = 0; #1;
      while (!bus.wready && t < 50) begin @(negedge aclk); #1; t++; end
      if (t >= 50) timeout_fail("w_handshake");
      @(negedge aclk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    t = 0; #1;
    while (!bus.bvalid && t < 50) begin @(negedge aclk); #1; t++; end
    if (t >= 50) timeout_fail("b_handshake");
    resp = bus.bresp; id_out = bus.bid;
    @(negedge aclk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input bit toggle);
    int t, n, beats;
    bit stalled;
    logic [31:0] hd;
    logic hl;
    bus.araddr = addr; bus.arlen = len; bus.arid = id; bus.arvalid = 1'b1;
    t = 0; #1;
    while (!bus.arready && t < 50) begin @(negedge aclk); #1; t++; end
    if (t >= 50) timeout_fail("ar_handshake");
    @(negedge aclk);
    bus.arvalid = 1'b0;
    n = 1; beats = 0; stalled = 0; rd_first = -1; lastmask = '0; hd = '0; hl = 1'b0;
    while (beats <= int'(len) && n < 200) begin
      bus.rready = toggle ? n[0] : 1'b1;
      #1;
      if (bus.rvalid) begin
        if (rd_first < 0) rd_first = n;
        if (stalled && (bus.rdata !== hd || bus.rlast !== hl)) stable_err++;
        if (bus.rready) begin
          if (beats < 16) begin rd[beats] = bus.rdata; lastmask[beats] = bus.rlast; end
          rid_seen = bus.rid;
          beats++;
          stalled = 0;
        end else begin
          stalled = 1; hd = bus.rdata; hl = bus.rlast;
        end
      end
      @(negedge aclk);
      n++;
    end
    bus.rready = 1'b0;
    if (beats <= int'(len)) timeout_fail("r_beats");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] resp;
    logic [3:0] bidv;
    int t;

    bus.arid = 4'd0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = 4'd0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    stable_err = 0;

    // Reset with both address channels already requesting.
    aresetn = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 32'h100; bus.arlen = 8'd0; bus.arid = 4'd5;
    bus.awvalid = 1'b1; bus.awaddr = 32'h1000; bus.awlen = 8'd3; bus.awid = 4'd9;
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_arready", {31'd0, bus.arready}, 32'd0);
    chk("rst_awready", {31'd0, bus.awready}, 32'd0);
    chk("rst_wready",  {31'd0, bus.wready},  32'd0);
    chk("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
    chk("rst_rlast",   {31'd0, bus.rlast},   32'd0);
    chk("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
    chk("rst_ids",     {24'd0, bus.rid, bus.bid}, 32'd0);
    chk("rst_resps",   {28'd0, bus.rresp, bus.bresp}, 32'd0);
    chk("rst_rdata",   bus.rdata, 32'd0);

    // Both valid in the first cycle after reset: read wins, write follows.
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("arb_first_arready", {31'd0, bus.arready}, 32'd1);
    chk("arb_first_awready", {31'd0, bus.awready}, 32'd0);
    @(negedge aclk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    t = 0; #1;
    while (!bus.rvalid && t < 20) begin @(negedge aclk); #1; t++; end
    if (t >= 20) timeout_fail("arb_read_beat");
    chk("arb_read_rlast", {31'd0, bus.rlast}, 32'd1);
    chk("arb_read_rid", {28'd0, bus.rid}, 32'd5);
    @(negedge aclk);
    bus.rready = 1'b0; bus.arvalid = 1'b1;
    #1;
    chk("arb_second_awready", {31'd0, bus.awready}, 32'd1);
    chk("arb_second_arready", {31'd0, bus.arready}, 32'd0);
    bus.arvalid = 1'b0;

    // Four-beat write then read back.
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    axi_write(32'h1000, 8'd3, 4'hF, 3, 4'd9, resp, bidv);
    chk("w4_bresp", {30'd0, resp}, 32'd0);
    chk("w4_bid", {28'd0, bidv}, 32'd9);
    axi_read(32'h1000, 8'd3, 4'd3, 1'b0);
    chk("r4_latency", rd_first, 32'd2);
    chk("r4_beat0", rd[0], 32'h11);
    chk("r4_beat1", rd[1], 32'h22);
    chk("r4_beat2", rd[2], 32'h33);
    chk("r4_beat3", rd[3], 32'h44);
    chk("r4_rlast_mask", {16'd0, lastmask}, 32'h0008);
    chk("r4_rid", {28'd0, rid_seen}, 32'd3);
    #1;
    chk("r4_no_extra_beat", {31'd0, bus.rvalid}, 32'd0);

    // Byte strobes over a zeroed word.
    wd[0] = 32'h0;
    axi_write(32'h2000, 8'd0, 4'hF, 0, 4'd1, resp, bidv);
    wd[0] = 32'hAABBCCDD;
    axi_write(32'h2000, 8'd0, 4'b0101, 0, 4'd2, resp, bidv);
    chk("strb_bresp", {30'd0, resp}, 32'd0);
    axi_read(32'h2000, 8'd0, 4'd4, 1'b0);
    chk("strb_data", rd[0], 32'h00BB00DD);

    // Eight-beat read with rready toggling.
    for (int i = 0; i < 8; i++) wd[i] = 32'hC0DE0000 + i;
    axi_write(32'h3000, 8'd7, 4'hF, 7, 4'd6, resp, bidv);
    chk("w8_bresp", {30'd0, resp}, 32'd0);
    stable_err = 0;
    axi_read(32'h3000, 8'd7, 4'd7, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("r8_beat%0d", i), rd[i], 32'hC0DE0000 + i);
    chk("r8_rlast_mask", {16'd0, lastmask}, 32'h0080);
    chk("r8_stall_stable", stable_err, 32'd0);

    // Early wlast and missing wlast both earn SLVERR but still write.
    wd[0] = 32'h5555AAAA; wd[1] = 32'h12345678;
    axi_write(32'h0400, 8'd1, 4'hF, 0, 4'd8, resp, bidv);
    chk("early_wlast_bresp", {30'd0, resp}, 32'h2);
    axi_read(32'h0400, 8'd1, 4'd0, 1'b0);
    chk("early_wlast_beat0", rd[0], 32'h5555AAAA);
    chk("early_wlast_beat1", rd[1], 32'h12345678);
    wd[0] = 32'h0BADF00D;
    axi_write(32'h0400, 8'd0, 4'hF, -1, 4'd8, resp, bidv);
    chk("no_wlast_bresp", {30'd0, resp}, 32'h2);

    // Burst from the top word wraps to word 0.
    wd[0] = 32'hFEEDFACE; wd[1] = 32'hCAFEBABE;
    axi_write(32'h3FFC, 8'd1, 4'hF, 1, 4'd2, resp, bidv);
    chk("wrap_bresp", {30'd0, resp}, 32'd0);
    axi_read(32'h0000, 8'd0, 4'd1, 1'b0);
    chk("wrap_word0", rd[0], 32'hCAFEBABE);
    axi_read(32'h3FFC, 8'd1, 4'd1, 1'b0);
    chk("wrap_read_top", rd[0], 32'hFEEDFACE);
    chk("wrap_read_low", rd[1], 32'hCAFEBABE);
    axi_read(32'h5000, 8'd0, 4'd1, 1'b0);
    chk("alias_read", rd[0], 32'h11);

    // Reset in the middle of a read burst.
    bus.araddr = 32'h3000; bus.arlen = 8'd7; bus.arid = 4'd7; bus.arvalid = 1'b1;
    t = 0; #1;
    while (!bus.arready && t < 50) begin @(negedge aclk); #1; t++; end
    if (t >= 50) timeout_fail("midrst_ar");
    @(negedge aclk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    chk("midrst_rvalid_before", {31'd0, bus.rvalid}, 32'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("midrst_rlast", {31'd0, bus.rlast}, 32'd0);
    chk("midrst_rdata", bus.rdata, 32'd0);
    @(negedge aclk);
    bus.rready = 1'b0;
    aresetn = 1'b1;
    axi_read(32'h1000, 8'd0, 4'd2, 1'b0);
    chk("postrst_data", rd[0], 32'h11);
    chk("postrst_rlast_mask", {16'd0, lastmask}, 32'h0001);
    chk("postrst_rid", {28'd0, rid_seen}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving word-index width (RAM depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have port aclk  input  1  single clock for all logic.
REQ-003 SHALL have port aresetn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port arid  input  4  read ID.
REQ-005 SHALL have port araddr  input  32  read start byte address.
REQ-006 SHALL have port arlen  input  8  read beats minus one.
REQ-007 SHALL have port arvalid  input  1  read address valid.
REQ-008 SHALL have port arready  output  1  read address accepted.
REQ-009 SHALL have port rid  output  4  echoed arid.
REQ-010 SHALL have port rdata  output  32  read beat data.
REQ-011 SHALL have port rresp  output  2  read response.
REQ-012 SHALL have port rlast  output  1  final read beat.
REQ-013 SHALL have port rvalid  output  1  read beat valid.
REQ-014 SHALL have port rready  input  1  master accepts beat.
REQ-015 SHALL have port awid  input  4  write ID.
REQ-016 SHALL have port awaddr  input  32  write start byte address.
REQ-017 SHALL have port awlen  input  8  write beats minus one.
REQ-018 SHALL have port awvalid  input  1  write address valid.
REQ-019 SHALL have port awready  output  1  write address accepted.
REQ-020 SHALL have port wdata  input  32  write beat data.
REQ-021 SHALL have port wstrb  input  4  byte enables.
REQ-022 SHALL have port wlast  input  1  master's final-beat flag.
REQ-023 SHALL have port wvalid  input  1  write beat valid.
REQ-024 SHALL have port wready  output  1  write beat accepted.
REQ-025 SHALL have port bid  output  4  echoed awid.
REQ-026 SHALL have port bresp  output  2  write response.
REQ-027 SHALL have port bvalid  output  1  write response valid.
REQ-028 SHALL have port bready  input  1  master accepts response.

Function
REQ-029 SHALL implement FSM IDLE, RD, WR, BRESP; one transaction outstanding; only INCR, 4-byte beats supported.
REQ-030 In IDLE: arready/awready high only for the granted channel; both valid -> grant channel not granted last; first grant after reset is read.
REQ-031 AR handshake -> RD; latch arid, word index araddr[ADDR_W+1:2], beat counter 0; address bits above ADDR_W+1 ignored (aliasing).
REQ-032 First rvalid SHALL assert 2 cycles after AR handshake; with rready held high, beats back-to-back, one per cycle.
REQ-033 rdata/rlast/rid SHALL hold stable while rvalid=1 and rready=0; no beat dropped or duplicated.
REQ-034 Word index SHALL increment by 1 per beat, wrapping modulo 2^ADDR_W; rlast=1 exactly on beat arlen; rresp always 2'b00.
REQ-035 Handshake on final beat -> IDLE; next AR/AW may be accepted the following cycle.
REQ-036 AW handshake -> WR; wready=1 in WR; each wvalid&&wready writes bytes whose wstrb bit is 1, then index+1 (same wrap).
REQ-037 WR SHALL end on beat count awlen regardless of wlast; bresp=2'b10 if wlast was not 1 on exactly that beat (wlast earlier or missing), else 2'b00; writes still performed.
REQ-038 BRESP: bvalid=1 with bid held until bready, then IDLE.
REQ-039 Read after write to same address SHALL return the written data.

Reset
REQ-040 aresetn low SHALL immediately force IDLE, read priority, and arready=awready=wready=rvalid=rlast=bvalid=0, rid=bid=0, rresp=bresp=0, rdata=0; in-flight bursts discarded.
REQ-041 RAM contents SHALL NOT be reset.

Structure
REQ-042 FSM state encoding and AXI response constants (OKAY, SLVERR) SHALL reside in the shared AXI package.
REQ-043 Storage SHALL be one sub-module axi_ram_bank: byte-enabled, synchronous-read single-port RAM, 1-cycle read latency.

Verification
REQ-044 Write 0x1000 awlen=3, data 11,22,33,44, wstrb=F, wlast on beat 3 -> bresp=00; read 0x1000 arlen=3 -> 11,22,33,44, rlast on 4th beat.
REQ-045 Write 0x2000 data 0xAABBCCDD wstrb=0101 over 0x00000000 -> read returns 0x00BB00DD.
REQ-046 arvalid and awvalid both raised in cycle after reset -> read granted first, write granted next.
REQ-047 Read arlen=7 with rready toggling 1,0 -> 8 beats in order, data stable during stalls.
REQ-048 Write awlen=1 with wlast on beat 0 -> 2 beats written, bresp=10; write starting at last word (ADDR_W=12, 0x3FFC) awlen=1 -> second beat lands at 0x0000.
REQ-049 aresetn low mid read burst -> rvalid=0 same cycle; after release, new read completes normally.
